// File: rtl/hall_pkg.sv
// Shared register map, bit positions and the STATUS layout for the Hall-sensor period meter.
package hall_pkg;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int STAT_VALID   = 0;
  localparam int STAT_STALLED = 1;
  localparam int STAT_NEW     = 2;
  localparam int STAT_OVERRUN = 3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // Field order matches the STATUS word, overrun in bit 3 down to valid in bit 0.
  typedef struct packed {
    logic overrun;
    logic is_new;
    logic stalled;
    logic valid;
  } status_t;

  function automatic logic [31:0] status_word(status_t s);
    return {28'd0, s};
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser followed by a run-length debounce filter on the raw Hall level.
module hall_debounce
  import hall_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic hall_in,
  output logic hall_filt
);

  localparam logic [15:0] RUN_LAST = 16'(DEBOUNCE_CYC - 1);

  logic        sync1_q, sync2_q;
  logic        filt_q, filt_d;
  logic [15:0] run_q, run_d;

  // The filtered level only flips after the synced level has disagreed with it for DEBOUNCE_CYC cycles in a row.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == RUN_LAST) begin
        filt_d = ~filt_q;
      end else begin
        run_d = run_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= hall_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      run_q   <= run_d;
    end
  end

  assign hall_filt = filt_q;

endmodule

// File: rtl/hall_period_meter.sv
// Wheel-speed meter: debounced Hall input, rising-edge period capture, edge counter and a 4-word slave.
// Optional interrupt output is built when HALL_PERIOD_IRQ_EN is defined.
module hall_period_meter
  import hall_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500,
  parameter int TIMEOUT_CYC  = 5000000,
  parameter int PERIOD_W     = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hall_in,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
`ifdef HALL_PERIOD_IRQ_EN
  output logic        irq,
`endif
  output logic        hall_filt
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = PERIOD_W'(TIMEOUT_CYC - 1);
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  logic                filt;
  logic                filt_prev_q;
  logic                rise;

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [31:0]         count_q, count_d;
  status_t             status_q, status_d;
  logic                armed_q, armed_d;
  logic                enable_q, enable_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_en_bit;

  logic                rd_period, wr_status, wr_control;
  logic                clear, ovr_w1c, at_max;

  hall_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .hall_in  (hall_in),
    .hall_filt(filt)
  );

  assign rise       = filt & ~filt_prev_q;
  assign rd_period  = avs_read  && (avs_address == ADDR_PERIOD);
  assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
  assign wr_control = avs_write && (avs_address == ADDR_CONTROL);
  assign clear      = wr_control && avs_writedata[CTRL_CLEAR];
  assign ovr_w1c    = wr_status  && avs_writedata[STAT_OVERRUN];
  assign at_max     = (cnt_q == CNT_MAX);

`ifdef HALL_PERIOD_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic unused_wdata;
  assign unused_wdata = ^{avs_writedata[31:4]};
  assign irq_en_bit   = irq_en_q;
  assign irq          = status_q.is_new & irq_en_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_control) irq_en_d = avs_writedata[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk) begin
    if (reset) irq_en_q <= 1'b0;
    else       irq_en_q <= irq_en_d;
  end
`else
  // Without the interrupt option the irq_enable bit has no register behind it.
  logic unused_wdata;
  assign unused_wdata = ^{avs_writedata[31:4], avs_writedata[CTRL_IRQ_EN]};
  assign irq_en_bit   = 1'b0;
`endif

  // Bus side effects are applied first so a capture in the same cycle overrides them.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    count_d  = count_q;
    status_d = status_q;
    armed_d  = armed_q;
    enable_d = enable_q;

    if (rd_period)  status_d.is_new  = 1'b0;
    if (ovr_w1c)    status_d.overrun = 1'b0;
    if (wr_control) enable_d         = avs_writedata[CTRL_ENABLE];

    if (clear) begin
      cnt_d            = '0;
      period_d         = '0;
      count_d          = '0;
      status_d.valid   = 1'b0;
      status_d.is_new  = 1'b0;
      status_d.overrun = 1'b0;
      armed_d          = 1'b0;
    end else if (enable_q) begin
      if (rise) begin
        cnt_d = '0;
        if (armed_q) begin
          period_d        = cnt_q + CNT_ONE;
          status_d.valid  = 1'b1;
          status_d.is_new = 1'b1;
          if (status_q.is_new) status_d.overrun = 1'b1;
        end
        armed_d          = 1'b1;
        status_d.stalled = 1'b0;
        count_d          = count_q + 32'd1;
      end else if (at_max) begin
        status_d.stalled = 1'b1;
        status_d.valid   = 1'b0;
        armed_d          = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      // Keeping armed low while disabled means the first edge after re-enable only arms.
      armed_d = 1'b0;
    end
  end

  // Reads return the register contents from before this cycle's update.
  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      unique case (avs_address)
        ADDR_STATUS:  readdata_d = status_word(status_q);
        ADDR_PERIOD:  readdata_d = status_q.stalled ? 32'd0 : 32'(period_q);
        ADDR_COUNT:   readdata_d = count_q;
        ADDR_CONTROL: readdata_d = {29'd0, irq_en_bit, 1'b0, enable_q};
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_prev_q <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      count_q     <= '0;
      status_q    <= '0;
      armed_q     <= 1'b0;
      enable_q    <= 1'b1;
      readdata_q  <= '0;
    end else begin
      filt_prev_q <= filt;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      count_q     <= count_d;
      status_q    <= status_d;
      armed_q     <= armed_d;
      enable_q    <= enable_d;
      readdata_q  <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign hall_filt    = filt;

endmodule

// File: tb/tb_hall_period_meter.sv
// Self-checking bench for hall_period_meter with an event-level model of filtered edges, captures and stalls.
// Irq checks are included when HALL_PERIOD_IRQ_EN is defined.
module tb_hall_period_meter;
  import hall_pkg::*;

  localparam int DEB     = 4;
  localparam int TIMEOUT = 1000;
  localparam int LAT     = DEB + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hall_in = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        hall_filt;
  logic        irq;

  hall_period_meter #(
    .DEBOUNCE_CYC(DEB),
    .TIMEOUT_CYC (TIMEOUT),
    .PERIOD_W    (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hall_in      (hall_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
`ifdef HALL_PERIOD_IRQ_EN
    .irq          (irq),
`endif
    .hall_filt    (hall_filt)
  );

`ifndef HALL_PERIOD_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  // Model: each rising edge of the filtered level takes effect LAT edges after hall_in rises.
  // The anchor is the edge at which the period counter last sat at zero; disabled edges push it forward.
  int          rise_q[$];
  int          last_eff;
  int          m_anchor;
  int          m_period;
  logic [31:0] m_count;
  logic        m_valid, m_stalled, m_new, m_ovr, m_armed, m_en, m_irqen;

  function automatic logic [31:0] model_read(input logic [1:0] addr);
    case (addr)
      ADDR_STATUS:  return {28'd0, m_ovr, m_new, m_stalled, m_valid};
      ADDR_PERIOD:  return m_stalled ? 32'd0 : 32'(m_period);
      ADDR_COUNT:   return m_count;
      default:      return {29'd0, m_irqen, 1'b0, m_en};
    endcase
  endfunction

  task automatic model_reset(input int e);
    m_anchor = e; m_period = 0; m_count = 0;
    m_valid = 0; m_stalled = 0; m_new = 0; m_ovr = 0; m_armed = 0;
    m_en = 1; m_irqen = 0;
    rise_q.delete();
  endtask

  task automatic model_edge(input int e, input logic rd, input logic [1:0] addr,
                            input logic wr, input logic [31:0] wd);
    logic rise, clr, stall, new_before;
    while (rise_q.size() > 0 && rise_q[0] < e) void'(rise_q.pop_front());
    rise = 1'b0;
    if (rise_q.size() > 0 && rise_q[0] == e) begin
      rise = 1'b1;
      void'(rise_q.pop_front());
    end
    clr        = wr && addr == ADDR_CONTROL && wd[1];
    stall      = m_en && !rise && !clr && (e - m_anchor >= TIMEOUT);
    new_before = m_new;
    if (rd && addr == ADDR_PERIOD) m_new = 0;
    if (wr && addr == ADDR_STATUS && wd[3]) m_ovr = 0;
    if (clr) begin
      m_anchor = e; m_period = 0; m_count = 0;
      m_valid = 0; m_new = 0; m_ovr = 0; m_armed = 0;
    end else if (m_en) begin
      if (rise) begin
        if (m_armed) begin
          m_period = e - m_anchor;
          m_valid  = 1;
          m_new    = 1;
          if (new_before) m_ovr = 1;
        end
        m_armed = 1; m_stalled = 0; m_count = m_count + 1; m_anchor = e;
      end else if (stall) begin
        m_stalled = 1; m_valid = 0; m_armed = 0;
      end
    end else begin
      m_armed  = 0;
      m_anchor = m_anchor + 1;
    end
    if (wr && addr == ADDR_CONTROL) begin
      m_en = wd[0];
`ifdef HALL_PERIOD_IRQ_EN
      m_irqen = wd[2];
`endif
    end
  endtask

  // One clock edge with the given bus request; returns read data and the model's expectation.
  task automatic step(input logic rd, input logic [1:0] addr, input logic wr, input logic [31:0] wd,
                      output logic [31:0] got, output logic [31:0] exp);
    avs_read = rd; avs_address = addr; avs_write = wr; avs_writedata = wd;
    exp = model_read(addr);
    @(posedge clk);
    cyc++;
    if (reset) model_reset(cyc);
    else       model_edge(cyc, rd, addr, wr, wd);
    #1;
    got = avs_readdata;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [31:0] g, x;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 32'd0, g, x);
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] got, output logic [31:0] exp);
    step(1'b1, addr, 1'b0, 32'd0, got, exp);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    logic [31:0] g, x;
    step(1'b0, addr, 1'b1, data, g, x);
  endtask

  task automatic hall_rise;
    hall_in = 1'b1;
    rise_q.push_back(cyc + LAT);
    last_eff = cyc + LAT;
  endtask

  task automatic hall_fall;
    hall_in = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    n_total++; if (avs_readdata !== 32'd0) $display("[TB] FAIL reset_readdata got=%h exp=0", avs_readdata); else n_pass++;
    n_total++; if (hall_filt !== 1'b0) $display("[TB] FAIL reset_filt got=%b exp=0", hall_filt); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), got, exp);
      n_total++;
      if (got !== exp || got !== ((a == 3) ? 32'd1 : 32'd0))
        $display("[TB] FAIL reset_reg%0d got=%h exp=%h", a, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_square_wave;
    logic [31:0] got, exp;
    int c0;
    hall_rise();
    c0 = cyc;
    idle(5);
    n_total++; if (hall_filt !== 1'b0) $display("[TB] FAIL filt_early got=%b exp=0", hall_filt); else n_pass++;
    idle(1);
    n_total++; if (hall_filt !== 1'b1 || cyc - c0 != 6) $display("[TB] FAIL filt_latency got=%b exp=1", hall_filt); else n_pass++;
    idle(4);
    bus_read(ADDR_COUNT, got, exp);
    n_total++; if (got !== exp || got !== 32'd1) $display("[TB] FAIL first_count got=%0d exp=%0d", got, exp); else n_pass++;
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_VALID] !== 1'b0) $display("[TB] FAIL first_status got=%h exp=%h", got, exp); else n_pass++;
    idle(88); hall_fall(); idle(100);
    hall_rise(); idle(10);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got !== 32'h5) $display("[TB] FAIL second_status got=%h exp=%h", got, exp); else n_pass++;
    bus_read(ADDR_PERIOD, got, exp);
    n_total++; if (got !== exp || got !== 32'd200) $display("[TB] FAIL period_200 got=%0d exp=%0d", got, exp); else n_pass++;
    idle(88); hall_fall(); idle(100);
  endtask

  task automatic test_glitch;
    logic [31:0] got, exp;
    hall_in = 1'b1; idle(3); hall_in = 1'b0; idle(10);
    n_total++; if (hall_filt !== 1'b0) $display("[TB] FAIL glitch_filt got=%b exp=0", hall_filt); else n_pass++;
    bus_read(ADDR_COUNT, got, exp);
    n_total++; if (got !== exp || got !== 32'd2) $display("[TB] FAIL glitch_count got=%0d exp=%0d", got, exp); else n_pass++;
    hall_rise(); idle(4); hall_fall(); idle(2);
    n_total++; if (hall_filt !== 1'b1) $display("[TB] FAIL pulse4_filt got=%b exp=1", hall_filt); else n_pass++;
    idle(20);
    bus_read(ADDR_COUNT, got, exp);
    n_total++; if (got !== exp || got !== 32'd3) $display("[TB] FAIL pulse4_count got=%0d exp=%0d", got, exp); else n_pass++;
  endtask

  task automatic test_stall;
    logic [31:0] got, exp;
    int e;
    hall_rise(); idle(75); hall_fall(); idle(75);
    hall_rise(); idle(75); hall_fall();
    e = last_eff;
    idle(e + 999 - cyc);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_STALLED] !== 1'b0 || got[STAT_VALID] !== 1'b1)
      $display("[TB] FAIL pre_stall got=%h exp=%h", got, exp); else n_pass++;
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_STALLED] !== 1'b1 || got[STAT_VALID] !== 1'b0)
      $display("[TB] FAIL stalled got=%h exp=%h", got, exp); else n_pass++;
    bus_read(ADDR_PERIOD, got, exp);
    n_total++; if (got !== exp || got !== 32'd0) $display("[TB] FAIL stall_period got=%0d exp=%0d", got, exp); else n_pass++;
    hall_rise(); idle(20);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[1:0] !== 2'b00) $display("[TB] FAIL rearm_status got=%h exp=%h", got, exp); else n_pass++;
    idle(129); hall_fall(); idle(150);
    hall_rise(); idle(20);
    bus_read(ADDR_PERIOD, got, exp);
    n_total++; if (got !== exp || got !== 32'd300) $display("[TB] FAIL period_300 got=%0d exp=%0d", got, exp); else n_pass++;
    idle(29); hall_fall(); idle(50);
  endtask

  task automatic test_overrun;
    logic [31:0] got, exp;
    hall_rise(); idle(50); hall_fall(); idle(50);
    hall_rise(); idle(50); hall_fall(); idle(50);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_OVERRUN] !== 1'b1) $display("[TB] FAIL overrun_set got=%h exp=%h", got, exp); else n_pass++;
    bus_write(ADDR_STATUS, 32'h8);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_OVERRUN] !== 1'b0) $display("[TB] FAIL overrun_w1c got=%h exp=%h", got, exp); else n_pass++;
    bus_read(ADDR_PERIOD, got, exp);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_NEW] !== 1'b0) $display("[TB] FAIL new_cleared got=%h exp=%h", got, exp); else n_pass++;
    idle(90);
    // Land a PERIOD read exactly on the capture edge.
    hall_rise(); idle(LAT - 1);
    bus_read(ADDR_PERIOD, got, exp);
    n_total++; if (got !== exp || got !== 32'd100) $display("[TB] FAIL read_vs_capture got=%0d exp=%0d", got, exp); else n_pass++;
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_NEW] !== 1'b1) $display("[TB] FAIL new_kept got=%h exp=%h", got, exp); else n_pass++;
    idle(41); hall_fall(); idle(50);
    // Land an overrun write-1-to-clear on a capture edge that raises overrun.
    hall_rise(); idle(LAT - 1);
    bus_write(ADDR_STATUS, 32'h8);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_OVERRUN] !== 1'b1) $display("[TB] FAIL w1c_vs_capture got=%h exp=%h", got, exp); else n_pass++;
    idle(40); hall_fall(); idle(50);
  endtask

  task automatic test_random_periods;
    logic [31:0] got, exp;
    int hi, lo, off, nrd;
    logic [1:0] a;
    for (int it = 0; it < 10; it++) begin
      hi  = $urandom_range(16, 400);
      lo  = $urandom_range(16, 400);
      off = $urandom_range(0, 9);
      nrd = $urandom_range(1, 3);
      hall_rise(); idle(off);
      for (int r = 0; r < nrd; r++) begin
        a = 2'($urandom_range(0, 3));
        bus_read(a, got, exp);
        n_total++; if (got !== exp) $display("[TB] FAIL rand_read it=%0d addr=%0d got=%h exp=%h", it, a, got, exp); else n_pass++;
      end
      idle(hi - off - nrd); hall_fall(); idle(lo);
    end
    for (int a2 = 0; a2 < 3; a2++) begin
      bus_read(2'(a2), got, exp);
      n_total++; if (got !== exp) $display("[TB] FAIL rand_final addr=%0d got=%h exp=%h", a2, got, exp); else n_pass++;
    end
  endtask

  task automatic test_clear_enable;
    logic [31:0] got, exp;
    bus_write(ADDR_CONTROL, 32'h3);
    bus_read(ADDR_COUNT, got, exp);
    n_total++; if (got !== exp || got !== 32'd0) $display("[TB] FAIL clear_count got=%0d exp=%0d", got, exp); else n_pass++;
    bus_read(ADDR_PERIOD, got, exp);
    n_total++; if (got !== exp || got !== 32'd0) $display("[TB] FAIL clear_period got=%0d exp=%0d", got, exp); else n_pass++;
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || (got & 32'hD) !== 32'd0) $display("[TB] FAIL clear_status got=%h exp=%h", got, exp); else n_pass++;
    bus_read(ADDR_CONTROL, got, exp);
    n_total++; if (got !== exp || got !== 32'd1) $display("[TB] FAIL clear_ctrl got=%h exp=%h", got, exp); else n_pass++;
    bus_write(ADDR_CONTROL, 32'h0);
    hall_rise(); idle(20); hall_fall(); idle(20);
    hall_rise(); idle(20); hall_fall(); idle(20);
    bus_read(ADDR_COUNT, got, exp);
    n_total++; if (got !== exp || got !== 32'd0) $display("[TB] FAIL frozen_count got=%0d exp=%0d", got, exp); else n_pass++;
    bus_write(ADDR_CONTROL, 32'h1);
    hall_rise(); idle(20);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_VALID] !== 1'b0) $display("[TB] FAIL reenable_arm got=%h exp=%h", got, exp); else n_pass++;
    idle(9); hall_fall(); idle(30);
    hall_rise(); idle(20);
    bus_read(ADDR_PERIOD, got, exp);
    n_total++; if (got !== exp || got !== 32'd60) $display("[TB] FAIL reenable_period got=%0d exp=%0d", got, exp); else n_pass++;
    idle(20); hall_fall(); idle(30);
  endtask

  task automatic test_irq_and_reset;
    logic [31:0] got, exp;
    bus_write(ADDR_CONTROL, 32'h5);
    bus_read(ADDR_CONTROL, got, exp);
    n_total++; if (got !== exp) $display("[TB] FAIL ctrl_irq_bit got=%h exp=%h", got, exp); else n_pass++;
    hall_rise(); idle(40); hall_fall(); idle(40);
    hall_rise(); idle(20);
`ifdef HALL_PERIOD_IRQ_EN
    n_total++; if (irq !== 1'b1 || irq !== (m_new & m_irqen)) $display("[TB] FAIL irq_set got=%b exp=1", irq); else n_pass++;
`endif
    bus_read(ADDR_PERIOD, got, exp);
    n_total++; if (got !== exp || got !== 32'd80) $display("[TB] FAIL irq_period got=%0d exp=%0d", got, exp); else n_pass++;
`ifdef HALL_PERIOD_IRQ_EN
    n_total++; if (irq !== 1'b0) $display("[TB] FAIL irq_clear got=%b exp=0", irq); else n_pass++;
`endif
    idle(30); hall_fall();
    reset = 1'b1; idle(2); reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), got, exp);
      n_total++;
      if (got !== exp || got !== ((a == 3) ? 32'd1 : 32'd0))
        $display("[TB] FAIL midreset_reg%0d got=%h exp=%h", a, got, exp);
      else n_pass++;
    end
    n_total++; if (irq !== 1'b0) $display("[TB] FAIL midreset_irq got=%b exp=0", irq); else n_pass++;
    hall_rise(); idle(20);
    bus_read(ADDR_STATUS, got, exp);
    n_total++; if (got !== exp || got[STAT_VALID] !== 1'b0) $display("[TB] FAIL post_reset_arm got=%h exp=%h", got, exp); else n_pass++;
    bus_read(ADDR_COUNT, got, exp);
    n_total++; if (got !== exp || got !== 32'd1) $display("[TB] FAIL post_reset_count got=%0d exp=%0d", got, exp); else n_pass++;
  endtask

  initial begin
    #(500_000);
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_square_wave();
    test_glitch();
    test_stall();
    test_overrun();
    test_random_periods();
    test_clear_enable();
    test_irq_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
